// File: rtl/and_unit_arbiter_pkg.sv
// Shared definitions for the two-requester arbiter in front of the bitwise AND/NAND unit.
package and_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_RESPOND = 2'd2
    } arb_state_e;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

    localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/and_unit_arbiter_if.sv
// Requester, shared-unit and response signals of the arbiter, with both sides as modports.
interface and_unit_arbiter_if
    import and_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_andflag;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_andflag;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_andflag;
    logic [WIDTH-1:0] alu_out;

    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic             resp_id;
    logic             busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_andflag,
        output req1_valid, req1_a, req1_b, req1_andflag,
        output alu_out, resp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_andflag,
        input  resp_valid, resp_data, resp_id, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_andflag,
        input  req1_valid, req1_a, req1_b, req1_andflag,
        input  alu_out, resp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_andflag,
        output resp_valid, resp_data, resp_id, busy
    );

endinterface

// File: rtl/and_unit_arbiter_rr.sv
// Two-way round-robin arbiter: the pointer names the side that wins a tie and
// moves to the loser's side whenever a grant is taken with advance high.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic rr_ptr_q;
    logic rr_ptr_d;
    logic [1:0] grant_s;

    // Grant selection; a lone requester always wins regardless of the pointer.
    always_comb begin
        grant_s = 2'b00;
        case (req)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = rr_ptr_q ? 2'b10 : 2'b01;
            default: grant_s = 2'b00;
        endcase
    end

    // Pointer update: favour the other side after each taken grant.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance && grant_s[0]) begin
            rr_ptr_d = 1'b1;
        end else if (advance && grant_s[1]) begin
            rr_ptr_d = 1'b0;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Pointer register, requester 0 favoured out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign grant = grant_s;

endmodule

// File: rtl/and_unit_arbiter.sv
// Shares one combinational AND/NAND unit between two requesters: grant, drive
// registered operands, wait a fixed settle time, capture and hand back the result.
module and_unit_arbiter
    import and_arb_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    and_unit_arbiter_if.slave  bus
);

    localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("and_unit_arbiter: SETTLE_CYCLES must be at least 1");
    end

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             alu_andflag_q, alu_andflag_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_id_q, resp_id_d;

    logic             idle_s;
    logic [1:0]       req_s;
    logic [1:0]       grant_s;

    // Requests only reach the arbiter in IDLE, so readys are 0 everywhere else.
    always_comb begin
        idle_s = (state_q == ST_IDLE);
        if (idle_s) begin
            req_s = {bus.req1_valid, bus.req0_valid};
        end else begin
            req_s = 2'b00;
        end
    end

    rr_arbiter_2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_s),
        .advance (idle_s),
        .grant   (grant_s)
    );

    // Next-state, operand load, settle countdown and response handshake.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_andflag_d = alu_andflag_q;
        resp_data_d   = resp_data_q;
        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s[0]) begin
                    alu_a_d       = bus.req0_a;
                    alu_b_d       = bus.req0_b;
                    alu_andflag_d = bus.req0_andflag;
                    resp_id_d     = ID_REQ0;
                    cnt_d         = CNT_INIT;
                    state_d       = ST_SETTLE;
                end else if (grant_s[1]) begin
                    alu_a_d       = bus.req1_a;
                    alu_b_d       = bus.req1_b;
                    alu_andflag_d = bus.req1_andflag;
                    resp_id_d     = ID_REQ1;
                    cnt_d         = CNT_INIT;
                    state_d       = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_ZERO) begin
                    resp_data_d  = bus.alu_out;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESPOND;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_RESPOND: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_RESPOND;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= CNT_ZERO;
            alu_a_q       <= {WIDTH{1'b0}};
            alu_b_q       <= {WIDTH{1'b0}};
            alu_andflag_q <= 1'b0;
            resp_data_q   <= {WIDTH{1'b0}};
            resp_valid_q  <= 1'b0;
            resp_id_q     <= ID_REQ0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_andflag_q <= alu_andflag_d;
            resp_data_q   <= resp_data_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
        end
    end

    assign bus.req0_ready  = grant_s[0];
    assign bus.req1_ready  = grant_s[1];
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_andflag = alu_andflag_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_data   = resp_data_q;
    assign bus.resp_id     = resp_id_q;
    assign bus.busy        = (state_q != ST_IDLE);

endmodule
